// File: rtl/memory_arbiter.sv
// ---------------------------------------------------------------------------
// memory_arbiter
//
// Two-port round-robin arbiter that funnels cache requests onto a single
// memory bus. One transaction is in flight at a time:
//   IDLE -> ISSUE (bus_request_valid for one cycle) -> WAIT -> RESPOND -> IDLE
//
// Ports
//   clock                        rising-edge clock
//   reset                        asynchronous, active-low reset
//   memory_request_0/1   [24:0]  {write, data[7:0], address[15:0]} from caches
//   memory_request_ready_0/1     request valid, held until response seen
//   memory_response_0/1  [15:0]  returned word (0 when port not responding)
//   memory_response_ready_0/1    response valid for the granted port
//   bus_request          [24:0]  forwarded request (0 outside ISSUE)
//   bus_request_valid            high for exactly the ISSUE cycle
//   bus_response         [15:0]  word read from memory
//   bus_response_valid           one-cycle strobe, only sampled in WAIT
//   bus_timeout                  sticky error flag, cleared only by reset
//
// Every output is driven from a register loaded with the value that
// corresponds to the next state, so outputs line up with the state register.
// ---------------------------------------------------------------------------
module memory_arbiter #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [24:0] memory_request_0,
    input  logic [24:0] memory_request_1,
    input  logic        memory_request_ready_0,
    input  logic        memory_request_ready_1,
    output logic [15:0] memory_response_0,
    output logic [15:0] memory_response_1,
    output logic        memory_response_ready_0,
    output logic        memory_response_ready_1,
    output logic [24:0] bus_request,
    output logic        bus_request_valid,
    input  logic [15:0] bus_response,
    input  logic        bus_response_valid,
    output logic        bus_timeout
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] ISSUE   = 2'd1;
    localparam logic [1:0] WAIT    = 2'd2;
    localparam logic [1:0] RESPOND = 2'd3;

    localparam logic [8:0] TIMEOUT_LIMIT = 9'(TIMEOUT_CYCLES);

    // Saturating increment for the 8-bit wait counter.
    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        if (value == 8'hFF) begin
            return 8'hFF;
        end else begin
            return value + 8'd1;
        end
    endfunction

    logic [1:0]  state_q,    state_d;
    logic        grant_q,    grant_d;     // port owning the current transaction
    logic        rr_q,       rr_d;        // port that wins the next contention
    logic [24:0] req_q,      req_d;
    logic [15:0] resp_q,     resp_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;
    logic        timeout_q,  timeout_d;

    logic [24:0] bus_req_q,       bus_req_d;
    logic        bus_req_valid_q, bus_req_valid_d;
    logic [15:0] rsp0_q,          rsp0_d;
    logic [15:0] rsp1_q,          rsp1_d;
    logic        rsp_rdy0_q,      rsp_rdy0_d;
    logic        rsp_rdy1_q,      rsp_rdy1_d;

    logic        granted_ready_s;
    logic        wait_expired_s;

    assign granted_ready_s = grant_q ? memory_request_ready_1 : memory_request_ready_0;
    // The counter holds (k-1) during the k-th WAIT cycle, so the limit is hit
    // once the upcoming increment would reach TIMEOUT_CYCLES.
    assign wait_expired_s  = (({1'b0, wait_cnt_q} + 9'd1) >= TIMEOUT_LIMIT);

    // Transaction state machine: next state, grant, captured request/response.
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        rr_d       = rr_q;
        req_d      = req_q;
        resp_d     = resp_q;
        wait_cnt_d = wait_cnt_q;
        timeout_d  = timeout_q;

        case (state_q)
            IDLE: begin
                if (memory_request_ready_0 && memory_request_ready_1) begin
                    // The pointer only moves on contention, so a port that lost
                    // and was then served alone still wins the next contention.
                    grant_d = rr_q;
                    rr_d    = ~rr_q;
                    req_d   = rr_q ? memory_request_1 : memory_request_0;
                    state_d = ISSUE;
                end else if (memory_request_ready_0) begin
                    grant_d = 1'b0;
                    req_d   = memory_request_0;
                    state_d = ISSUE;
                end else if (memory_request_ready_1) begin
                    grant_d = 1'b1;
                    req_d   = memory_request_1;
                    state_d = ISSUE;
                end else begin
                    state_d = IDLE;
                end
            end
            ISSUE: begin
                wait_cnt_d = 8'd0;
                state_d    = WAIT;
            end
            WAIT: begin
                wait_cnt_d = sat_inc8(wait_cnt_q);
                if (bus_response_valid) begin
                    resp_d  = bus_response;
                    state_d = RESPOND;
                end else if (wait_expired_s) begin
                    resp_d    = 16'hFFFF;
                    timeout_d = 1'b1;
                    state_d   = RESPOND;
                end else begin
                    state_d = WAIT;
                end
            end
            RESPOND: begin
                if (!granted_ready_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = RESPOND;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output values matching the next state, loaded into the output registers.
    always_comb begin
        bus_req_valid_d = 1'b0;
        bus_req_d       = 25'd0;
        rsp_rdy0_d      = 1'b0;
        rsp_rdy1_d      = 1'b0;
        rsp0_d          = 16'd0;
        rsp1_d          = 16'd0;

        if (state_d == ISSUE) begin
            bus_req_valid_d = 1'b1;
            bus_req_d       = req_d;
        end else begin
            bus_req_valid_d = 1'b0;
            bus_req_d       = 25'd0;
        end

        if (state_d == RESPOND) begin
            if (grant_d) begin
                rsp_rdy1_d = 1'b1;
                rsp1_d     = resp_d;
            end else begin
                rsp_rdy0_d = 1'b1;
                rsp0_d     = resp_d;
            end
        end else begin
            rsp_rdy0_d = 1'b0;
            rsp_rdy1_d = 1'b0;
        end
    end

    // State and output registers; reset abandons any transaction in flight.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q         <= IDLE;
            grant_q         <= 1'b0;
            rr_q            <= 1'b0;
            req_q           <= 25'd0;
            resp_q          <= 16'd0;
            wait_cnt_q      <= 8'd0;
            timeout_q       <= 1'b0;
            bus_req_q       <= 25'd0;
            bus_req_valid_q <= 1'b0;
            rsp0_q          <= 16'd0;
            rsp1_q          <= 16'd0;
            rsp_rdy0_q      <= 1'b0;
            rsp_rdy1_q      <= 1'b0;
        end else begin
            state_q         <= state_d;
            grant_q         <= grant_d;
            rr_q            <= rr_d;
            req_q           <= req_d;
            resp_q          <= resp_d;
            wait_cnt_q      <= wait_cnt_d;
            timeout_q       <= timeout_d;
            bus_req_q       <= bus_req_d;
            bus_req_valid_q <= bus_req_valid_d;
            rsp0_q          <= rsp0_d;
            rsp1_q          <= rsp1_d;
            rsp_rdy0_q      <= rsp_rdy0_d;
            rsp_rdy1_q      <= rsp_rdy1_d;
        end
    end

    assign bus_request             = bus_req_q;
    assign bus_request_valid       = bus_req_valid_q;
    assign memory_response_0       = rsp0_q;
    assign memory_response_1       = rsp1_q;
    assign memory_response_ready_0 = rsp_rdy0_q;
    assign memory_response_ready_1 = rsp_rdy1_q;
    assign bus_timeout             = timeout_q;

endmodule

// File: tb/tb_memory_arbiter.sv
// ---------------------------------------------------------------------------
// tb_memory_arbiter
//
// Directed bench for memory_arbiter: single read, contention with
// round-robin, write forwarding, bus timeout (sticky), early request drop,
// and reset in the middle of a transaction. Inputs change 1 time unit after
// the rising edge; outputs are sampled 1-2 time units after it.
// ---------------------------------------------------------------------------
module tb_memory_arbiter;

    logic        clock;
    logic        reset;
    logic [24:0] memory_request_0;
    logic [24:0] memory_request_1;
    logic        memory_request_ready_0;
    logic        memory_request_ready_1;
    logic [15:0] memory_response_0;
    logic [15:0] memory_response_1;
    logic        memory_response_ready_0;
    logic        memory_response_ready_1;
    logic [24:0] bus_request;
    logic        bus_request_valid;
    logic [15:0] bus_response;
    logic        bus_response_valid;
    logic        bus_timeout;

    int total_q;
    int bad_q;
    int wait_n;

    memory_arbiter #(.TIMEOUT_CYCLES(255)) dut (
        .clock                   (clock),
        .reset                   (reset),
        .memory_request_0        (memory_request_0),
        .memory_request_1        (memory_request_1),
        .memory_request_ready_0  (memory_request_ready_0),
        .memory_request_ready_1  (memory_request_ready_1),
        .memory_response_0       (memory_response_0),
        .memory_response_1       (memory_response_1),
        .memory_response_ready_0 (memory_response_ready_0),
        .memory_response_ready_1 (memory_response_ready_1),
        .bus_request             (bus_request),
        .bus_request_valid       (bus_request_valid),
        .bus_response            (bus_response),
        .bus_response_valid      (bus_response_valid),
        .bus_timeout             (bus_timeout)
    );

    // Free-running 10-unit clock.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_q = total_q + 1;
        assert (obs === exp) else begin
            bad_q = bad_q + 1;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_rdy0"}, 32'(memory_response_ready_0), 32'd0);
        check({tag, "_rdy1"}, 32'(memory_response_ready_1), 32'd0);
        check({tag, "_rsp0"}, 32'(memory_response_0), 32'd0);
        check({tag, "_rsp1"}, 32'(memory_response_1), 32'd0);
        check({tag, "_breq"}, 32'(bus_request), 32'd0);
        check({tag, "_bval"}, 32'(bus_request_valid), 32'd0);
    endtask

    initial begin
        total_q = 0;
        bad_q   = 0;
        reset                  = 1'b0;
        memory_request_0       = 25'd0;
        memory_request_1       = 25'd0;
        memory_request_ready_0 = 1'b0;
        memory_request_ready_1 = 1'b0;
        bus_response           = 16'd0;
        bus_response_valid     = 1'b0;

        // ---- reset state ----
        tick();
        tick();
        check_idle_outputs("rst");
        check("rst_timeout", 32'(bus_timeout), 32'd0);
        reset = 1'b1;
        tick();

        // ---- port 0 read of address 22, bus answers after 2 WAIT cycles ----
        memory_request_0       = {1'b0, 8'd0, 16'd22};
        memory_request_ready_0 = 1'b1;
        tick();                                   // ISSUE
        check("a_bval", 32'(bus_request_valid), 32'd1);
        check("a_breq", 32'(bus_request), 32'h0000016);
        tick();                                   // WAIT 1
        check("a_bval_w", 32'(bus_request_valid), 32'd0);
        check("a_breq_w", 32'(bus_request), 32'd0);
        tick();                                   // WAIT 2
        check("a_rdy0_w", 32'(memory_response_ready_0), 32'd0);
        bus_response       = 16'h1900;
        bus_response_valid = 1'b1;
        tick();                                   // RESPOND
        bus_response_valid = 1'b0;
        check("a_rdy0", 32'(memory_response_ready_0), 32'd1);
        check("a_rsp0", 32'(memory_response_0), 32'h1900);
        check("a_rdy1", 32'(memory_response_ready_1), 32'd0);
        check("a_rsp1", 32'(memory_response_1), 32'd0);
        tick();                                   // still RESPOND, ready held
        check("a_rdy0_hold", 32'(memory_response_ready_0), 32'd1);
        check("a_rsp0_hold", 32'(memory_response_0), 32'h1900);
        memory_request_ready_0 = 1'b0;
        tick();                                   // IDLE
        check("a_rdy0_done", 32'(memory_response_ready_0), 32'd0);

        // ---- contention after reset: port 0 first, then port 1 ----
        memory_request_0       = {1'b0, 8'd0, 16'h0010};
        memory_request_1       = {1'b0, 8'd0, 16'h0020};
        memory_request_ready_0 = 1'b1;
        memory_request_ready_1 = 1'b1;
        tick();                                   // ISSUE port 0
        check("b_breq_p0", 32'(bus_request), 32'h0000010);
        tick();                                   // WAIT
        bus_response       = 16'hAAAA;
        bus_response_valid = 1'b1;
        tick();                                   // RESPOND port 0
        bus_response_valid = 1'b0;
        check("b_rdy0", 32'(memory_response_ready_0), 32'd1);
        check("b_rsp0", 32'(memory_response_0), 32'hAAAA);
        check("b_rdy1_low", 32'(memory_response_ready_1), 32'd0);
        memory_request_ready_0 = 1'b0;
        tick();                                   // IDLE
        check("b_idle_bval", 32'(bus_request_valid), 32'd0);
        tick();                                   // ISSUE port 1 (pending)
        check("b_bval_p1", 32'(bus_request_valid), 32'd1);
        check("b_breq_p1", 32'(bus_request), 32'h0000020);
        tick();                                   // WAIT
        bus_response       = 16'hBBBB;
        bus_response_valid = 1'b1;
        tick();                                   // RESPOND port 1
        bus_response_valid = 1'b0;
        check("b_rdy1", 32'(memory_response_ready_1), 32'd1);
        check("b_rsp1", 32'(memory_response_1), 32'hBBBB);
        check("b_rdy0_low", 32'(memory_response_ready_0), 32'd0);
        check("b_rsp0_zero", 32'(memory_response_0), 32'd0);
        memory_request_ready_1 = 1'b0;
        tick();                                   // IDLE
        // second contention: port 1 wins
        memory_request_0       = {1'b0, 8'd0, 16'h0030};
        memory_request_1       = {1'b0, 8'd0, 16'h0040};
        memory_request_ready_0 = 1'b1;
        memory_request_ready_1 = 1'b1;
        tick();                                   // ISSUE port 1
        check("b2_breq_p1", 32'(bus_request), 32'h0000040);
        tick();
        bus_response       = 16'h4444;
        bus_response_valid = 1'b1;
        tick();                                   // RESPOND port 1
        bus_response_valid = 1'b0;
        check("b2_rdy1", 32'(memory_response_ready_1), 32'd1);
        check("b2_rsp1", 32'(memory_response_1), 32'h4444);
        memory_request_ready_1 = 1'b0;
        tick();                                   // IDLE
        tick();                                   // ISSUE port 0
        check("b2_breq_p0", 32'(bus_request), 32'h0000030);
        tick();
        bus_response       = 16'h3333;
        bus_response_valid = 1'b1;
        tick();                                   // RESPOND port 0
        bus_response_valid = 1'b0;
        check("b2_rdy0", 32'(memory_response_ready_0), 32'd1);
        check("b2_rsp0", 32'(memory_response_0), 32'h3333);
        memory_request_ready_0 = 1'b0;
        tick();                                   // IDLE

        // ---- port 1 write, forwarded unchanged ----
        memory_request_1       = {1'b1, 8'd255, 16'd34};
        memory_request_ready_1 = 1'b1;
        tick();                                   // ISSUE
        check("c_bval", 32'(bus_request_valid), 32'd1);
        check("c_breq", 32'(bus_request), 32'h1FF0022);
        tick();                                   // WAIT
        check("c_bval_once", 32'(bus_request_valid), 32'd0);
        bus_response       = 16'h00FF;
        bus_response_valid = 1'b1;
        tick();                                   // RESPOND
        bus_response_valid = 1'b0;
        check("c_rdy1", 32'(memory_response_ready_1), 32'd1);
        check("c_rsp1", 32'(memory_response_1), 32'h00FF);
        check("c_rdy0", 32'(memory_response_ready_0), 32'd0);
        memory_request_ready_1 = 1'b0;
        tick();                                   // IDLE

        // ---- bus timeout after 255 silent WAIT cycles ----
        memory_request_0       = {1'b0, 8'd0, 16'h0050};
        memory_request_ready_0 = 1'b1;
        tick();                                   // ISSUE
        tick();                                   // WAIT 1
        check("d_timeout_pre", 32'(bus_timeout), 32'd0);
        wait_n = 0;
        while (!memory_response_ready_0 && wait_n < 300) begin
            tick();
            wait_n = wait_n + 1;
        end
        check("d_wait_cycles", 32'(wait_n), 32'd255);
        check("d_rsp0", 32'(memory_response_0), 32'hFFFF);
        check("d_timeout", 32'(bus_timeout), 32'd1);
        memory_request_ready_0 = 1'b0;
        tick();                                   // IDLE
        memory_request_0       = {1'b0, 8'd0, 16'h0060};
        memory_request_ready_0 = 1'b1;
        tick();                                   // ISSUE
        tick();                                   // WAIT
        bus_response       = 16'h6060;
        bus_response_valid = 1'b1;
        tick();                                   // RESPOND
        bus_response_valid = 1'b0;
        check("d_rsp0_ok", 32'(memory_response_0), 32'h6060);
        check("d_timeout_sticky", 32'(bus_timeout), 32'd1);
        memory_request_ready_0 = 1'b0;
        tick();                                   // IDLE

        // ---- request dropped during WAIT: one-cycle RESPOND ----
        memory_request_0       = {1'b0, 8'd0, 16'h0070};
        memory_request_ready_0 = 1'b1;
        tick();                                   // ISSUE
        tick();                                   // WAIT
        memory_request_ready_0 = 1'b0;
        bus_response       = 16'h1234;
        bus_response_valid = 1'b1;
        tick();                                   // RESPOND
        bus_response_valid = 1'b0;
        check("f_rdy0", 32'(memory_response_ready_0), 32'd1);
        check("f_rsp0", 32'(memory_response_0), 32'h1234);
        tick();                                   // IDLE
        check("f_rdy0_drop", 32'(memory_response_ready_0), 32'd0);
        tick();
        check("f_idle_bval", 32'(bus_request_valid), 32'd0);

        // ---- reset during WAIT, late bus response ignored ----
        memory_request_0       = {1'b0, 8'd0, 16'h0080};
        memory_request_ready_0 = 1'b1;
        tick();                                   // ISSUE
        tick();                                   // WAIT
        reset = 1'b0;
        #1;
        check_idle_outputs("e_rst");
        check("e_rst_timeout", 32'(bus_timeout), 32'd0);
        memory_request_ready_0 = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        bus_response       = 16'hDEAD;
        bus_response_valid = 1'b1;
        tick();
        bus_response_valid = 1'b0;
        check_idle_outputs("e_late");
        tick();
        check_idle_outputs("e_late2");
        // contention right after reset: port 0 wins again
        memory_request_0       = {1'b0, 8'd0, 16'h0090};
        memory_request_1       = {1'b0, 8'd0, 16'h00A0};
        memory_request_ready_0 = 1'b1;
        memory_request_ready_1 = 1'b1;
        tick();                                   // ISSUE from IDLE
        check("e_bval", 32'(bus_request_valid), 32'd1);
        check("e_breq_p0", 32'(bus_request), 32'h0000090);

        $display("test done: total=%0d bad=%0d", total_q, bad_q);
        $finish;
    end

endmodule

// File: doc/memory_arbiter.md
MEMORY_ARBITER -- requirements
Module: memory_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255: maximum number of WAIT cycles before a bus timeout.
REQ-002 SHALL have port clock  input  1  single clock; all state SHALL update on the rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have ports memory_request_0 / memory_request_1  input  25  cache request, formatted as {write[24], data[23:16], address[15:0]}.
REQ-005 SHALL have ports memory_request_ready_0 / memory_request_ready_1  input  1  request valid, held high by the cache until the response is seen.
REQ-006 SHALL have ports memory_response_0 / memory_response_1  output  16  returned word; low byte is at the even address, high byte at the even address + 1.
REQ-007 SHALL have ports memory_response_ready_0 / memory_response_ready_1  output  1  response valid.
REQ-008 SHALL have port bus_request  output  25  forwarded request, same format as memory_request_*.
REQ-009 SHALL have port bus_request_valid  output  1  bus_request is valid.
REQ-010 SHALL have port bus_response  input  16  word read from memory.
REQ-011 SHALL have port bus_response_valid  input  1  one-cycle strobe marking bus_response valid.
REQ-012 SHALL have port bus_timeout  output  1  sticky error flag.

Function
REQ-013 SHALL implement the states IDLE, ISSUE, WAIT and RESPOND.
REQ-014 In IDLE, with exactly one request_ready high, SHALL grant that port, register its request, and go to ISSUE on the next edge.
REQ-015 In IDLE, with both request_ready high, SHALL grant the port not granted last time (round-robin); port 0 SHALL win the first contention after reset.
REQ-016 The registered request SHALL NOT change until the next IDLE.
REQ-017 In ISSUE, SHALL drive bus_request_valid high and bus_request equal to the registered request for exactly one cycle, then go to WAIT.
REQ-018 In WAIT, SHALL capture bus_response when bus_response_valid is 1 and go to RESPOND.
REQ-019 In WAIT, SHALL increment a wait counter each cycle.
REQ-020 In WAIT, when the wait counter reaches TIMEOUT_CYCLES with no bus_response_valid, SHALL capture 16'hFFFF, set bus_timeout, and go to RESPOND.
REQ-021 bus_response_valid arriving in any state other than WAIT SHALL be ignored.
REQ-022 In RESPOND, SHALL hold the granted port's memory_response_ready high and memory_response equal to the captured word.
REQ-023 In RESPOND, SHALL return to IDLE on the first edge where the granted port's request_ready is low (four-phase handshake).
REQ-024 SHALL hold memory_response_ready of the non-granted port low at all times.
REQ-025 SHALL drive memory_response of the non-granted port to 16'd0.
REQ-026 A request from the losing port SHALL stay pending and be granted on the first IDLE cycle after the current transaction completes.
REQ-027 Minimum latency from request_ready rising to memory_response_ready rising SHALL be 3 cycles: grant, ISSUE, and a WAIT in which the bus response is immediate.
REQ-028 A request_ready that drops during ISSUE or WAIT SHALL NOT abort the bus transaction; RESPOND SHALL then last one cycle.
REQ-029 Write requests SHALL be forwarded unchanged.
REQ-030 For write requests, the bus SHALL return the post-write aligned word, and that word SHALL be returned to the requester like a read.
REQ-031 SHALL NOT clear address[0]; address alignment is the bus's responsibility.
REQ-032 The wait counter SHALL be 8 bits wide, SHALL saturate, and SHALL clear on entry to WAIT.

Reset
REQ-033 While reset is low, SHALL force: state IDLE, both memory_response_ready low, both memory_response 16'd0, bus_request 25'd0, bus_request_valid low, bus_timeout low, round-robin pointer set so port 0 wins next, wait counter 0.
REQ-034 Reset asserted mid-transaction SHALL abandon the transaction immediately with no response; the requester SHALL re-issue.
REQ-035 bus_timeout SHALL clear only on reset.

Verification
REQ-036 Bench SHALL cover: port 0 read {0,8'd0,16'd22}, bus returns 16'h1900 after 2 WAIT cycles -> memory_response_0 = 16'h1900 with ready high until request_ready_0 drops; port 1 ready stays low.
REQ-037 Bench SHALL cover: both ports request in the same cycle after reset -> port 0 served first, port 1 granted the IDLE cycle after port 0's handshake completes; with both requesting again next time -> port 1 served first.
REQ-038 Bench SHALL cover: port 1 write {1,8'd255,16'd34} -> bus_request = 25'h1FF0022 valid for exactly 1 cycle; bus returns 16'h00FF -> memory_response_1 = 16'h00FF.
REQ-039 Bench SHALL cover: no bus_response_valid for 255 WAIT cycles -> memory_response_0 = 16'hFFFF, bus_timeout = 1 and still 1 after the next successful transaction.
REQ-040 Bench SHALL cover: reset pulled low during WAIT -> all outputs at reset values within the same cycle; a late bus_response_valid after reset is released -> ignored, state stays IDLE.
REQ-041 Bench SHALL cover: request_ready_0 dropped during WAIT -> response_ready_0 high for exactly 1 cycle, then IDLE.
